// File: rtl/asmd_multiplier_core_pkg.sv
// Shared definitions for the shift-and-add multiplier: controller state encoding
// and the width of the iteration counter.
package asmd_multiplier_core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WORD_LENGTH = 4;

    // One spare bit so the counter can represent word_length itself.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/asmd_multiplier_core_datapath.sv
// Datapath of the shift-and-add multiplier: operand/accumulator registers,
// iteration counter and the conditional adder.
module asmd_mult_datapath
    import asmd_multiplier_core_pkg::*;
#(
    parameter int word_length = DEFAULT_WORD_LENGTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_i,
    input  logic                       shift_i,
    input  logic [word_length-1:0]     word0_i,
    input  logic [word_length-1:0]     word1_i,
    output logic [2*word_length-1:0]   acc_sum_o,
    output logic                       last_o
);

    localparam int CW = cnt_width(word_length);

    logic [2*word_length-1:0] mcand_q, mcand_d;
    logic [word_length-1:0]   mplier_q, mplier_d;
    logic [2*word_length-1:0] acc_q, acc_d;
    logic [CW-1:0]            count_q, count_d;
    logic [2*word_length-1:0] addend;

    // acc_sum_o is the accumulator value after the current iteration; the
    // controller captures it directly on the final iteration.
    always_comb begin
        addend    = mplier_q[0] ? mcand_q : '0;
        acc_sum_o = acc_q + addend;
        last_o    = (count_q == CW'(word_length - 1));
    end

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        if (load_i) begin
            mcand_d  = {{word_length{1'b0}}, word0_i};
            mplier_d = word1_i;
            acc_d    = '0;
            count_d  = '0;
        end else if (shift_i) begin
            acc_d    = acc_sum_o;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/asmd_multiplier_core.sv
// Sequential unsigned shift-and-add multiplier: controller FSM and output
// registers; arithmetic lives in asmd_mult_datapath.
module asmd_multiplier_core
    import asmd_multiplier_core_pkg::*;
#(
    parameter int word_length = DEFAULT_WORD_LENGTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [word_length-1:0]     word0,
    input  logic [word_length-1:0]     word1,
    output logic [2*word_length-1:0]   product,
    output logic                       ready
);

    state_e                   state_q, state_d;
    logic [2*word_length-1:0] product_q, product_d;
    logic                     ready_q, ready_d;
    logic                     load, shift;
    logic [2*word_length-1:0] acc_sum;
    logic                     last;

    asmd_mult_datapath #(
        .word_length (word_length)
    ) u_datapath (
        .clk       (clk),
        .reset     (reset),
        .load_i    (load),
        .shift_i   (shift),
        .word0_i   (word0),
        .word1_i   (word1),
        .acc_sum_o (acc_sum),
        .last_o    (last)
    );

    always_comb begin
        state_d   = state_q;
        product_d = product_q;
        ready_d   = ready_q;
        load      = 1'b0;
        shift     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    ready_d = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                shift = 1'b1;
                if (last) begin
                    product_d = acc_sum;
                    ready_d   = 1'b1;
                    state_d   = DONE;
                end
            end
            // Wait for start to drop so a held request cannot retrigger.
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            product_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            product_q <= product_d;
            ready_q   <= ready_d;
        end
    end

    assign product = product_q;
    assign ready   = ready_q;

endmodule

// File: tb/tb_asmd_multiplier_core.sv
// Self-checking bench for asmd_multiplier_core: table of operand pairs with
// expected products, a scoreboard queue, and hand sequences for reset/busy corners.
module tb_asmd_multiplier_core;

    localparam int W = 4;

    logic           clk;
    logic           reset;
    logic           start;
    logic [W-1:0]   word0;
    logic [W-1:0]   word1;
    logic [2*W-1:0] product;
    logic           ready;

    asmd_multiplier_core #(.word_length(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .word0   (word0),
        .word1   (word1),
        .product (product),
        .ready   (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   w0;
        logic [W-1:0]   w1;
        logic [2*W-1:0] exp;
        int             hold;
        bit             disturb;
    } vec_t;

    vec_t           vecs[10];
    logic [2*W-1:0] sb[$];
    logic [2*W-1:0] model_product;
    int             n_vec;
    int             n_fail;
    logic           ready_prev;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Completion monitor: every rising ready must deliver the oldest queued result.
    always @(negedge clk) begin
        if (reset !== 1'b1 && ready === 1'b1 && ready_prev !== 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_ready", 16'(ready), 16'd0);
            end else begin
                chk("sb_product", 16'(product), 16'(sb.pop_front()));
            end
        end
        ready_prev = ready;
    end

    task automatic run_op(input logic [W-1:0] w0, input logic [W-1:0] w1,
                          input logic [2*W-1:0] exp, input int hold, input bit disturb);
        sb.push_back(exp);
        word0 = w0;
        word1 = w1;
        start = 1'b1;
        @(posedge clk); #1;
        if (hold == 0) start = 1'b0;
        chk("ready_fall", 16'(ready), 16'd0);
        for (int i = 1; i <= W; i++) begin
            @(posedge clk); #1;
            if (i < W) begin
                chk("busy_ready", 16'(ready), 16'd0);
                chk("busy_product", 16'(product), 16'(model_product));
            end else begin
                chk("done_ready", 16'(ready), 16'd1);
                chk("done_product", 16'(product), 16'(exp));
            end
            if (disturb && i < 3) begin
                word0 = W'($urandom);
                word1 = W'($urandom);
                start = (i == 1);
            end else if (hold == 0) begin
                start = 1'b0;
            end
        end
        model_product = exp;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_ready", 16'(ready), 16'd1);
            chk("hold_product", 16'(product), 16'(exp));
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk("idle_ready", 16'(ready), 16'd1);
        chk("idle_product", 16'(product), 16'(exp));
    endtask

    initial begin
        n_vec = 0;
        n_fail = 0;
        ready_prev = 1'b0;
        model_product = '0;
        vecs[0] = '{4'd4,  4'd5,  8'h14, 0,  1'b0};
        vecs[1] = '{4'd15, 4'd15, 8'hE1, 10, 1'b0};
        vecs[2] = '{4'd3,  4'd6,  8'h12, 0,  1'b0};
        vecs[3] = '{4'd0,  4'd7,  8'h00, 0,  1'b0};
        vecs[4] = '{4'd1,  4'd9,  8'h09, 0,  1'b0};
        vecs[5] = '{4'd10, 4'd13, 8'h82, 0,  1'b1};
        vecs[6] = '{4'd8,  4'd2,  8'h10, 0,  1'b0};
        vecs[7] = '{4'd15, 4'd1,  8'h0F, 0,  1'b1};
        vecs[8] = '{4'd7,  4'd0,  8'h00, 0,  1'b0};
        vecs[9] = '{4'd12, 4'd11, 8'h84, 0,  1'b0};

        // Reset held with a pending request: reset must dominate.
        reset = 1'b1;
        start = 1'b1;
        word0 = 4'd4;
        word1 = 4'd5;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_product", 16'(product), 16'd0);
            chk("rst_ready", 16'(ready), 16'd0);
        end
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", 16'(ready), 16'd0);

        for (int v = 0; v < 10; v++) begin
            run_op(vecs[v].w0, vecs[v].w1, vecs[v].exp, vecs[v].hold, vecs[v].disturb);
        end

        // Reset during the second BUSY cycle aborts without emitting a result.
        word0 = 4'd9;
        word1 = 4'd9;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_product", 16'(product), 16'd0);
        chk("abort_ready", 16'(ready), 16'd0);
        model_product = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("abort_idle_ready", 16'(ready), 16'd0);
        end
        run_op(4'd9, 4'd9, 8'h51, 0, 1'b0);
        run_op(4'd6, 4'd14, 8'h54, 0, 1'b0);

        chk("sb_drained", 16'(sb.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
